// File: rtl/adventure_room_fsm_pkg.sv
// rooms: room/game enums, landmark rooms and the 3x3 grid neighbour function.
package rooms;
  typedef enum logic [3:0] {R0, R1, R2, R3, R4, R5, R6, R7, R8} room_states;
  typedef enum logic [1:0] {PLAYING, WON, DEAD} game_state;
  typedef enum logic [1:0] {DIR_W, DIR_E, DIR_S, DIR_N} dir_t;
  typedef struct packed {
    room_states target;
    logic       wall;
  } hop_t;
  localparam room_states DRAGON_ROOM   = R4;
  localparam room_states TREASURE_ROOM = R8;
  localparam room_states ENTRY_ROOM    = R0;
  // Row-major grid; a wall hop returns the current room unchanged.
  function automatic hop_t neighbour(room_states r, dir_t d);
    logic [3:0] i, row, col, t;
    logic wall;
    i    = r;
    row  = i / 4'd3;
    col  = i % 4'd3;
    wall = d == DIR_N ? row == 4'd0 : d == DIR_S ? row == 4'd2 : d == DIR_E ? col == 4'd2 : col == 4'd0;
    t    = d == DIR_N ? i - 4'd3 : d == DIR_S ? i + 4'd3 : d == DIR_E ? i + 4'd1 : i - 4'd1;
    return '{target: room_states'(wall ? i : t), wall: wall};
  endfunction
endpackage

// File: rtl/adventure_room_fsm_if.sv
// adventure_room_fsm_if: buttons/treasure in, room/score/outcome out.
interface adventure_room_fsm_if import rooms::*; #(parameter int MOVE_W = 8);
  logic n, s, e, w, treasure;
  room_states room;
  logic [MOVE_W-1:0] moves;
  logic win, dead, bump;
  modport master (output n, s, e, w, treasure, input room, moves, win, dead, bump);
  modport slave (input n, s, e, w, treasure, output room, moves, win, dead, bump);
endinterface

// File: rtl/adventure_room_fsm_dir_edge_detect.sv
// dir_edge_detect: rising-edge detector on {n,s,e,w}; valid only for a single edge.
module dir_edge_detect import rooms::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic       valid,
  output dir_t       dir
);
  logic [3:0] prev, press;
  always_ff @(posedge clk or posedge reset)
    if (reset) prev <= '0;
    else prev <= btn;
  assign press = btn & ~prev;
  assign valid = $onehot(press);
  assign dir   = press[0] ? DIR_W : press[1] ? DIR_E : press[2] ? DIR_S : DIR_N;
endmodule

// File: rtl/adventure_room_fsm.sv
// adventure_room_fsm: player position/outcome FSM on a 3x3 grid; optional move budget under ADV_MOVE_LIMIT_EN.
module adventure_room_fsm import rooms::*; #(
  parameter int MOVE_W    = 8,
  parameter int MAX_MOVES = 20
) (
  input logic clk,
  input logic reset,
  adventure_room_fsm_if.slave io
);
`ifdef ADV_MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [MOVE_W-1:0] LIMIT = MOVE_W'(MAX_MOVES);
  game_state state_q, state_d;
  room_states room_q, room_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic bump_q, bump_d, valid, accept, exit_ok, dragon, limit_hit;
  dir_t dir;
  hop_t hop;
  dir_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .btn   ({io.n, io.s, io.e, io.w}),
    .valid (valid),
    .dir   (dir)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= PLAYING;
      room_q  <= ENTRY_ROOM;
      moves_q <= '0;
      bump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      room_q  <= room_d;
      moves_q <= moves_d;
      bump_q  <= bump_d;
    end
  // Leaving west through the entrance is the only wall hop that can be taken.
  always_comb begin
    hop       = neighbour(room_q, dir);
    exit_ok   = room_q == ENTRY_ROOM && dir == DIR_W && io.treasure;
    accept    = state_q == PLAYING && valid && (!hop.wall || exit_ok);
    bump_d    = state_q == PLAYING && valid && hop.wall && !exit_ok;
    room_d    = accept ? hop.target : room_q;
    moves_d   = accept && moves_q != '1 ? moves_q + 1'b1 : moves_q;
    dragon    = hop.target == DRAGON_ROOM && !io.treasure;
    limit_hit = LIMIT_EN && moves_d == LIMIT;
    state_d   = !accept ? state_q : exit_ok ? WON : dragon || limit_hit ? DEAD : PLAYING;
  end
  assign io.room  = room_q;
  assign io.moves = moves_q;
  assign io.win   = state_q == WON;
  assign io.dead  = state_q == DEAD;
  assign io.bump  = bump_q;
endmodule

// File: tb/tb_adventure_room_fsm.sv
// tb_adventure_room_fsm: directed scenarios plus random presses checked against a row/column game model.
module tb_adventure_room_fsm;
  import rooms::*;
  localparam int MW = 4, MAXM = 4;
`ifdef ADV_MOVE_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif
  localparam bit [3:0] N = 4'b1000, S = 4'b0100, E = 4'b0010, W = 4'b0001;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  adventure_room_fsm_if #(.MOVE_W(MW)) bus();
  adventure_room_fsm #(.MOVE_W(MW), .MAX_MOVES(MAXM)) dut (.clk(clk), .reset(reset), .io(bus));
  int tests = 0, fails = 0;
  int m_row, m_col, m_moves, m_state;
  bit m_bump;
  bit [3:0] m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_moves = 0; m_state = 0; m_bump = 0; m_prev = '0;
  endtask

  task automatic model_step(input bit [3:0] b, input bit t);
    bit [3:0] p;
    int nr, nc;
    bit acc;
    p = b & ~m_prev;
    m_prev = b;
    m_bump = 0;
    acc = 0;
    if (m_state == 0 && $countones(p) == 1) begin
      nr = m_row + (p[3] ? -1 : p[2] ? 1 : 0);
      nc = m_col + (p[1] ? 1 : p[0] ? -1 : 0);
      if (nr < 0 || nr > 2 || nc < 0 || nc > 2) begin
        if (m_row == 0 && m_col == 0 && p[0] && t) begin m_state = 1; acc = 1; end
        else m_bump = 1;
      end else begin
        m_row = nr; m_col = nc; acc = 1;
        if (nr == 1 && nc == 1 && !t) m_state = 2;
      end
      if (acc && m_moves < (1 << MW) - 1) m_moves++;
      if (acc && LIMIT_ON && m_state == 0 && m_moves == MAXM) m_state = 2;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_room"}, 32'(bus.room), m_row * 3 + m_col);
    check({tag, "_moves"}, 32'(bus.moves), m_moves);
    check({tag, "_win"}, 32'(bus.win), 32'(m_state == 1));
    check({tag, "_dead"}, 32'(bus.dead), 32'(m_state == 2));
    check({tag, "_bump"}, 32'(bus.bump), 32'(m_bump));
  endtask

  task automatic cycle(input bit [3:0] b, input bit t, input string tag);
    {bus.n, bus.s, bus.e, bus.w} = b;
    bus.treasure = t;
    @(posedge clk);
    model_step(b, t);
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic press(input bit [3:0] b, input bit t, input string tag);
    cycle(b, t, tag);
    cycle(4'b0, t, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit [3:0] b;
    int r;
    {bus.n, bus.s, bus.e, bus.w} = 4'b0;
    bus.treasure = 1'b0;
    @(negedge clk);
    model_reset();
    check_all("init");
    reset = 1'b0;
    cycle(4'b0, 0, "idle");
    cycle(N, 0, "wall_n");
    check("bump_pulse", 32'(bus.bump), 1);
    cycle(4'b0, 0, "wall_n_rel");
    check("bump_clear", 32'(bus.bump), 0);
    repeat (5) cycle(E, 0, "hold_e");
    cycle(4'b0, 0, "hold_e_rel");
    check("hold_moves", 32'(bus.moves), 1);
    check("hold_room", 32'(bus.room), 1);
    do_reset();
    press(E, 0, "walk"); press(E, 0, "walk"); press(S, 0, "walk"); press(S, 1, "walk");
    press(W, 1, "walk"); press(W, 1, "walk"); press(N, 1, "walk"); press(N, 1, "walk");
    press(W, 1, "walk_exit");
    press(E, 1, "after_win");
`ifndef ADV_MOVE_LIMIT_EN
    check("walk_win", 32'(bus.win), 1);
    check("walk_moves", 32'(bus.moves), 9);
    check("walk_room", 32'(bus.room), 0);
`endif
    do_reset();
    press(E, 0, "dragon"); press(S, 0, "dragon");
    check("dragon_dead", 32'(bus.dead), 1);
    check("dragon_room", 32'(bus.room), 4);
    check("dragon_moves", 32'(bus.moves), 2);
    press(N, 0, "after_dead");
    check("after_dead_room", 32'(bus.room), 4);
    do_reset();
    check("dead_cleared", 32'(bus.dead), 0);
    press(S, 0, "to_r3");
    cycle(N | E, 0, "dual");
    check("dual_room", 32'(bus.room), 3);
    check("dual_bump", 32'(bus.bump), 0);
    cycle(4'b0, 0, "dual_rel");
    cycle(S, 0, "held_s");
    do_reset();
    cycle(S, 0, "held_thru_reset");
    check("held_room", 32'(bus.room), 3);
    check("held_moves", 32'(bus.moves), 1);
    cycle(4'b0, 0, "held_rel");
    do_reset();
    press(E, 0, "bounce"); press(W, 0, "bounce"); press(E, 0, "bounce"); press(W, 0, "bounce");
    check("bounce_room", 32'(bus.room), 0);
    check("bounce_moves", 32'(bus.moves), 4);
    check("bounce_dead", 32'(bus.dead), 32'(LIMIT_ON));
    repeat (7) begin press(E, 0, "sat"); press(W, 0, "sat"); end
`ifndef ADV_MOVE_LIMIT_EN
    check("sat_moves", 32'(bus.moves), 15);
`endif
    do_reset();
    press(W, 0, "exit_locked");
    press(W, 1, "exit_open");
    check("exit_win", 32'(bus.win), 1);
    check("exit_moves", 32'(bus.moves), 1);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      b = r < 4 ? 4'b0 : r < 8 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cycle(b, 1'($urandom_range(0, 1)), "rand");
      if ((m_state != 0 && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0) do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
